// File: rtl/byte_lanes_pkg.sv
// Shared types and constants for the byte striping datapath.
// One byte stream is spread round-robin across LANES lanes.
package byte_lanes_pkg;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] PAD_BYTE = 8'hBC;

  typedef logic [WIDTH-1:0] lane_byte_t;
  typedef lane_byte_t [LANES-1:0] lane_group_t;
  typedef logic [1:0] lane_idx_t;

  typedef enum logic {FILL, HOLD} stage_state_t;
  typedef enum logic {EMPTY, FULL} out_state_t;

endpackage

// File: rtl/byte_striping_if.sv
// Byte-in / lane-group-out bus of the striping block.
// The slave modport is the striping block; the master modport is its environment.
interface byte_striping_if;
  import byte_lanes_pkg::*;

  lane_byte_t in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  lane_byte_t Lane_0;
  lane_byte_t Lane_1;
  lane_byte_t Lane_2;
  lane_byte_t Lane_3;
  logic       lanes_valid;
  logic       lanes_ready;
  lane_idx_t  lane_idx;
  logic       busy;

  modport master (
    output in_data, in_valid, flush, lanes_ready,
    input  in_ready, Lane_0, Lane_1, Lane_2, Lane_3, lanes_valid, lane_idx, busy
  );

  modport slave (
    input  in_data, in_valid, flush, lanes_ready,
    output in_ready, Lane_0, Lane_1, Lane_2, Lane_3, lanes_valid, lane_idx, busy
  );

endinterface

// File: rtl/byte_stripe_stage.sv
// Staging bank: collects bytes into a lane group, pads on flush, and holds a
// finished group while the output bank is still occupied.
module byte_stripe_stage
  import byte_lanes_pkg::*;
(
  input  logic        clk,
  input  logic        reset_L,
  input  lane_byte_t  in_data,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        out_free,
  output logic        in_ready,
  output lane_idx_t   lane_idx,
  output logic        stage_full,
  output logic        transfer,
  output lane_group_t group_data
);

  stage_state_t state_q, state_d;
  lane_idx_t    idx_q, idx_d;
  lane_group_t  stage_q, stage_d;
  logic         accept;
  logic         complete;
  logic [2:0]   fill_from;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= FILL;
      idx_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
    end
  end

  // A completed group resets the index at once, so a held group never looks partial.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    complete  = 1'b0;
    transfer  = 1'b0;
    accept    = in_valid && (state_q == FILL);
    fill_from = {1'b0, idx_q} + {2'b00, accept};
    if (state_q == FILL) begin
      if (accept) begin
        stage_d[idx_q] = in_data;
        idx_d          = idx_q + 2'd1;
      end
      complete = (accept && ((idx_q == 2'd3) || flush)) ||
                 (flush && (idx_q != 2'd0) && !accept);
      if (complete) begin
        for (int k = 0; k < LANES; k++) begin
          if (3'(k) >= fill_from) stage_d[k] = PAD_BYTE;
        end
        idx_d    = '0;
        transfer = out_free;
        if (!out_free) state_d = HOLD;
      end
    end else if (out_free) begin
      transfer = 1'b1;
      state_d  = FILL;
    end
  end

  assign in_ready   = (state_q == FILL);
  assign stage_full = (state_q == HOLD);
  assign lane_idx   = idx_q;
  assign group_data = stage_d;

endmodule

// File: rtl/byte_striping.sv
// Transmit-side byte striping: staging bank feeding a registered output bank,
// so input keeps flowing while a full group waits for the serializer.
module byte_striping
  import byte_lanes_pkg::*;
(
  input logic             clk,
  input logic             reset_L,
  byte_striping_if.slave  bus
);

  out_state_t  out_q, out_d;
  lane_group_t lanes_q, lanes_d;
  logic        out_free;
  logic        transfer;
  logic        stage_full;
  logic        stage_ready;
  lane_idx_t   stage_idx;
  lane_group_t group_data;

  assign out_free = (out_q == EMPTY) || bus.lanes_ready;

  byte_stripe_stage u_stage (
    .clk        (clk),
    .reset_L    (reset_L),
    .in_data    (bus.in_data),
    .in_valid   (bus.in_valid),
    .flush      (bus.flush),
    .out_free   (out_free),
    .in_ready   (stage_ready),
    .lane_idx   (stage_idx),
    .stage_full (stage_full),
    .transfer   (transfer),
    .group_data (group_data)
  );

  // A transfer on the same edge as a drain keeps the bank full with new data.
  always_comb begin
    out_d   = out_q;
    lanes_d = lanes_q;
    if (transfer) begin
      out_d   = FULL;
      lanes_d = group_data;
    end else if ((out_q == FULL) && bus.lanes_ready) begin
      out_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_q   <= EMPTY;
      lanes_q <= '0;
    end else begin
      out_q   <= out_d;
      lanes_q <= lanes_d;
    end
  end

  assign bus.in_ready    = stage_ready;
  assign bus.lane_idx    = stage_idx;
  assign bus.lanes_valid = (out_q == FULL);
  assign bus.Lane_0      = lanes_q[0];
  assign bus.Lane_1      = lanes_q[1];
  assign bus.Lane_2      = lanes_q[2];
  assign bus.Lane_3      = lanes_q[3];
  assign bus.busy        = (stage_idx != 2'd0) || stage_full || (out_q == FULL);

endmodule

// File: tb/tb_byte_striping.sv
// Scoreboard bench for byte_striping: groups are queued as the stimulus closes
// them and popped by a monitor whenever the DUT hands a group downstream.
module tb_byte_striping;
  import byte_lanes_pkg::*;

  logic clk = 1'b0;
  logic reset_L = 1'b1;

  always #5 clk = ~clk;

  byte_striping_if bus();

  byte_striping dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  lane_group_t exp_q[$];
  int          m_idx = 0;
  lane_group_t m_buf = '0;
  bit          m_full = 1'b0;
  bit          m_vld = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h, required %08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] laneWord();
    return {bus.Lane_3, bus.Lane_2, bus.Lane_1, bus.Lane_0};
  endfunction

  // Reference view of one clock edge; a closed group is queued for the monitor.
  task automatic modelEdge(input bit v, input lane_byte_t d, input bit f, input bit lr);
    bit acc;
    bit comp;
    bit ofree;
    ofree = !m_vld || lr;
    if (m_full) begin
      if (ofree) begin
        m_full = 1'b0;
        m_vld  = 1'b1;
      end
    end else begin
      acc  = v;
      comp = (acc && ((m_idx == 3) || f)) || (f && (m_idx != 0) && !acc);
      if (acc) m_buf[m_idx] = d;
      if (comp) begin
        for (int k = (acc ? m_idx + 1 : m_idx); k < LANES; k++) m_buf[k] = PAD_BYTE;
        exp_q.push_back(m_buf);
        m_idx = 0;
        if (ofree) m_vld = 1'b1;
        else m_full = 1'b1;
      end else begin
        if (acc) m_idx++;
        if (m_vld && lr) m_vld = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input lane_byte_t d, input bit v, input bit f, input bit lr);
    bus.in_data     = d;
    bus.in_valid    = v;
    bus.flush       = f;
    bus.lanes_ready = lr;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(!m_full));
    checkOutput("lanes_valid", 32'(bus.lanes_valid), 32'(m_vld));
    checkOutput("lane_idx", 32'(bus.lane_idx), 32'(m_idx));
    checkOutput("busy", 32'(bus.busy), 32'((m_idx != 0) || m_full || m_vld));
    @(posedge clk);
    modelEdge(v, d, f, lr);
    #1;
  endtask

  task automatic doReset();
    bus.in_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.lanes_ready = 1'b0;
    bus.in_data     = '0;
    reset_L = 1'b0;
    #1;
    checkOutput("rst_lane_idx", 32'(bus.lane_idx), 32'd0);
    checkOutput("rst_lanes_valid", 32'(bus.lanes_valid), 32'd0);
    checkOutput("rst_lanes", laneWord(), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    m_idx  = 0;
    m_full = 1'b0;
    m_vld  = 1'b0;
    m_buf  = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  // Downstream takes the group at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (reset_L && bus.lanes_valid && bus.lanes_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_group", laneWord(), 32'hxxxxxxxx);
      end else begin
        lane_group_t e;
        e = exp_q.pop_front();
        checkOutput("group", laneWord(), 32'(e));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.lanes_ready = 1'b0;
    #2;
    doReset();

    // Reset mid-group discards the partial bytes.
    applyStimulus(8'h21, 1, 0, 1);
    applyStimulus(8'h22, 1, 0, 1);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1, 0, 1);
    checkOutput("t1_group", laneWord(), 32'h13121110);
    applyStimulus(8'h00, 0, 0, 1);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1, 0, 1);
    checkOutput("t2_group0", laneWord(), 32'h04030201);
    for (int i = 5; i <= 8; i++) applyStimulus(8'(i), 1, 0, 1);
    checkOutput("t2_group1", laneWord(), 32'h08070605);
    applyStimulus(8'h00, 0, 0, 1);

    // Backpressure: second group stays in staging until the first drains.
    for (int i = 0; i < 8; i++) applyStimulus(8'hA0 + 8'(i), 1, 0, 0);
    checkOutput("t3_held", laneWord(), 32'hA3A2A1A0);
    applyStimulus(8'hA8, 1, 0, 0);
    applyStimulus(8'hA8, 1, 0, 1);
    checkOutput("t3_transfer", laneWord(), 32'hA7A6A5A4);
    applyStimulus(8'hA8, 1, 0, 0);
    applyStimulus(8'h00, 0, 1, 1);
    applyStimulus(8'h00, 0, 0, 1);

    // Flush of a partial group, then flush with nothing staged.
    applyStimulus(8'h55, 1, 0, 1);
    applyStimulus(8'h66, 1, 0, 1);
    applyStimulus(8'h00, 0, 1, 1);
    checkOutput("t4_pad", laneWord(), 32'hBCBC6655);
    applyStimulus(8'h00, 0, 0, 1);
    applyStimulus(8'h00, 0, 1, 1);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("t4_lanes_hold", laneWord(), 32'hBCBC6655);

    // Flush together with an accepted byte.
    applyStimulus(8'h01, 1, 0, 1);
    applyStimulus(8'h02, 1, 0, 1);
    applyStimulus(8'h03, 1, 0, 1);
    applyStimulus(8'h77, 1, 1, 1);
    checkOutput("t5_last_byte", laneWord(), 32'h77030201);
    applyStimulus(8'h11, 1, 0, 1);
    applyStimulus(8'h88, 1, 1, 1);
    checkOutput("t5_mid_byte", laneWord(), 32'hBCBC8811);
    applyStimulus(8'h00, 0, 0, 1);

    // Random stream under random backpressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0,
                    1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(8'h00, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 0, 0, 1);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
